generic_sram_byte_en: RTL and testbench
=======================================

GENERIC_SRAM_BYTE_EN -- requirements
Module: generic_sram_byte_en

Interface
REQ-001 Parameter DATA_WIDTH, default 128, SHALL set the word width in bits and SHALL be a multiple of 8 (minimum 8).
REQ-002 Parameter ADDRESS_WIDTH, default 7, SHALL set the word address width; depth = 2**ADDRESS_WIDTH words.
REQ-003 Port i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port i_reset  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 Port i_write_data  input  DATA_WIDTH  SHALL carry the write word.
REQ-006 Port i_write_enable  input  1  SHALL, when high, request a write this cycle.
REQ-007 Port i_address  input  ADDRESS_WIDTH  SHALL carry the word address, shared by read and write.
REQ-008 Port i_byte_enable  input  DATA_WIDTH/8  SHALL be the byte-lane mask; bit k qualifies data bits [8k+7:8k].
REQ-009 Port o_read_data  output  DATA_WIDTH  SHALL carry registered read data.

Function
REQ-010 Storage SHALL be a single-port array of 2**ADDRESS_WIDTH words of DATA_WIDTH bits.
REQ-011 On a rising edge with i_reset low and i_write_enable high, each byte lane k with i_byte_enable[k]=1 SHALL be written from i_write_data lane k at mem[i_address].
REQ-012 Byte lanes with i_byte_enable[k]=0 SHALL retain their previous contents.
REQ-013 i_write_enable high with i_byte_enable all zero SHALL leave memory unchanged but still counts as a write cycle for REQ-015.
REQ-014 On a rising edge with i_reset low and i_write_enable low, o_read_data SHALL load mem[i_address]; read latency is exactly one cycle.
REQ-015 On a rising edge with i_reset low and i_write_enable high, o_read_data SHALL load all zeros; no read-during-write forwarding.
REQ-016 o_read_data SHALL hold its value between rising edges and SHALL depend on no input combinationally.
REQ-017 Addresses SHALL be used as-is; the full range 0 to 2**ADDRESS_WIDTH-1 is valid, with no wrap or out-of-range case.
REQ-018 Back-to-back cycles SHALL be supported with no stall: write then read of the same address on the next edge returns the newly written data.
REQ-019 Memory contents SHALL initialise to all zeros at simulation start; synthesis imposes no initial value.

Reset
REQ-020 On a rising edge with i_reset high, o_read_data SHALL be cleared to all zeros.
REQ-021 While i_reset is high, writes SHALL be suppressed (memory unchanged) regardless of i_write_enable.
REQ-022 Reset SHALL NOT clear memory contents; data written before reset SHALL be readable after reset deasserts.
REQ-023 The first edge with i_reset low SHALL perform a normal read or write per REQ-011 to REQ-015.

Verification
REQ-024 DATA_WIDTH=32, ADDRESS_WIDTH=4; reset 2 cycles -> o_read_data = 0x00000000.
REQ-025 Write addr 3, data 0xDEADBEEF, byte_enable 0xF; next cycle read addr 3 -> o_read_data = 0xDEADBEEF one cycle after the read edge; o_read_data = 0 during the write cycle.
REQ-026 Then write addr 3, data 0x11223344, byte_enable 0x5; read addr 3 -> 0xDE22BE44.
REQ-027 Write addr 15, data 0xCAFEF00D, byte_enable 0xF; read addr 0 -> 0x00000000; read addr 15 -> 0xCAFEF00D.
REQ-028 Assert reset with i_write_enable high to addr 3, data 0xFFFFFFFF -> o_read_data = 0, memory unchanged; after reset, read addr 3 -> 0xDE22BE44.
REQ-029 Write all-zero byte_enable to addr 15 with data 0x0 -> read addr 15 still 0xCAFEF00D.

Source files
------------

// File: rtl/generic_sram_byte_en.sv
// Single-port synchronous SRAM with per-byte write enables and a registered read port.
// A write cycle returns zero on the read port; reset clears only the output register.
module generic_sram_byte_en #(
  parameter int DATA_WIDTH    = 128,
  parameter int ADDRESS_WIDTH = 7
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [DATA_WIDTH-1:0]     i_write_data,
  input  logic                      i_write_enable,
  input  logic [ADDRESS_WIDTH-1:0]  i_address,
  input  logic [DATA_WIDTH/8-1:0]   i_byte_enable,
  output logic [DATA_WIDTH-1:0]     o_read_data
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int LANES = DATA_WIDTH / 8;

  // Declaration initialiser gives zeroed contents in simulation; no reset path touches the array.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_read_data <= '0;
    end else if (i_write_enable) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (i_byte_enable[k]) begin
          mem[i_address][8*k +: 8] <= i_write_data[8*k +: 8];
        end
      end
      o_read_data <= '0;
    end else begin
      o_read_data <= mem[i_address];
    end
  end

endmodule

// File: tb/tb_generic_sram_byte_en.sv
// Scoreboard bench: the stimulus side predicts each cycle's read data, a negedge
// monitor pops predictions and compares them with the registered output.
module tb_generic_sram_byte_en;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic          write_enable = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW/8-1:0] byte_enable = '0;
  logic [DW-1:0] read_data;

  generic_sram_byte_en #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_write_data   (write_data),
    .i_write_enable (write_enable),
    .i_address      (address),
    .i_byte_enable  (byte_enable),
    .o_read_data    (read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] exp;
    string         tag;
  } item_t;

  item_t       sbq[$];
  item_t       cur;
  logic [DW-1:0] model [2**AW];
  int tests = 0;
  int fails = 0;

  // Reference: memory as an array of words; write merges enabled bytes, read returns the word.
  task automatic issue(input logic rst, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW/8-1:0] be,
                       input string tag, input bit use_fixed, input logic [DW-1:0] fixed);
    logic [DW-1:0] e;
    #1;
    reset = rst; write_enable = we; address = a; write_data = d; byte_enable = be;
    if (rst) e = '0;
    else if (we) begin
      for (int k = 0; k < DW/8; k++)
        if (be[k]) model[a][8*k +: 8] = d[8*k +: 8];
      e = '0;
    end else e = model[a];
    if (use_fixed) e = fixed;
    @(posedge clk);
    sbq.push_back('{e, tag});
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      cur = sbq.pop_front();
      tests++;
      if (read_data !== cur.exp) begin
        fails++;
        $display("FAIL %s: got %h expected %h", cur.tag, read_data, cur.exp);
      end
    end
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) model[i] = '0;

    issue(1, 0, 0, 0, 4'h0, "reset0", 1, 32'h0);
    issue(1, 0, 0, 0, 4'h0, "reset1", 1, 32'h0);
    issue(0, 1, 3, 32'hDEADBEEF, 4'hF, "wr3_out_zero", 1, 32'h0);
    issue(0, 0, 3, 32'h0, 4'h0, "rd3_full", 1, 32'hDEADBEEF);
    issue(0, 1, 3, 32'h11223344, 4'h5, "wr3_partial", 1, 32'h0);
    issue(0, 0, 3, 32'h0, 4'h0, "rd3_merged", 1, 32'hDE22BE44);
    issue(0, 1, 15, 32'hCAFEF00D, 4'hF, "wr15", 1, 32'h0);
    issue(0, 0, 0, 32'h0, 4'h0, "rd0_init_zero", 1, 32'h0);
    issue(0, 0, 15, 32'h0, 4'h0, "rd15_top", 1, 32'hCAFEF00D);
    issue(1, 1, 3, 32'hFFFFFFFF, 4'hF, "reset_blocks_write", 1, 32'h0);
    issue(0, 0, 3, 32'h0, 4'h0, "rd3_after_reset", 1, 32'hDE22BE44);
    issue(0, 1, 15, 32'h0, 4'h0, "wr15_no_lanes", 1, 32'h0);
    issue(0, 0, 15, 32'h0, 4'h0, "rd15_unchanged", 1, 32'hCAFEF00D);

    for (int n = 0; n < 600; n++) begin
      logic r, w;
      r = ($urandom_range(0, 19) == 0);
      w = $urandom_range(0, 1);
      issue(r, w, AW'($urandom_range(0, 2**AW - 1)), $urandom, (DW/8)'($urandom),
            r ? "rand_reset" : (w ? "rand_write" : "rand_read"), 0, '0);
    end
    issue(0, 0, 0, 0, 4'h0, "final_read", 0, '0);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
